// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - standard-FIFO to valid/ready stream adapter with 2-entry skid buffer
module fifo_reader #(
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk_rd,
  input  logic              rst_rd,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic [1:0]        level,
  output logic [CWIDTH-1:0] word_cnt
);

  // Buffer occupancy doubles as the level output.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] tail_q, tail_d;
  logic [CWIDTH-1:0] word_cnt_q, word_cnt_d;

  logic              xfer;
  logic [1:0]        occ;
  state_t            after_xfer;

  // Handshake, pop request and next-state: transfer first, then land the in-flight word.
  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    after_xfer = state_q;

    m_valid = (state_q != EMPTY) && !rst_rd;
    xfer    = m_valid && m_ready;
    occ     = state_q + {1'b0, inflight_q};

    // A pop may be issued into the slot that this cycle's transfer frees.
    fifo_read  = !rst_rd && !fifo_empty && ((occ < 2'd2) || ((occ == 2'd2) && xfer));
    inflight_d = fifo_read;
    word_cnt_d = word_cnt_q + {{(CWIDTH-1){1'b0}}, xfer};

    if (xfer) begin
      head_d     = tail_q;
      after_xfer = (state_q == FULL2) ? ONE : EMPTY;
    end

    // The word requested last cycle is on fifo_dout now and is always kept,
    // even if the FIFO went empty meanwhile.
    if (inflight_q) begin
      if (after_xfer == EMPTY) begin
        head_d  = fifo_dout;
        state_d = ONE;
      end else begin
        tail_d  = fifo_dout;
        state_d = FULL2;
      end
    end else begin
      state_d = after_xfer;
    end
  end

  // State register; reset drops buffered words and any pop in flight.
  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign m_data   = head_q;
  assign level    = state_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - scoreboard bench for fifo_reader
module tb_fifo_reader;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk_rd = 1'b0;
  logic          rst_rd;
  logic          fifo_read;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    level;
  logic [CW-1:0] word_cnt;

  always #5 clk_rd = ~clk_rd;

  fifo_reader #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk_rd    (clk_rd),
    .rst_rd    (rst_rd),
    .fifo_read (fifo_read),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .level     (level),
    .word_cnt  (word_cnt)
  );

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          inflight_m;

  logic          t_rd, t_emp, t_x, t_i;
  logic [DW-1:0] t_d;
  logic [1:0]    t_l;
  logic [DW-1:0] e;

  // One clock: sample at the falling edge, then model the standard FIFO after the rising edge.
  task automatic tick(output logic rd, output logic emp, output logic x,
                      output logic [DW-1:0] d, output logic [1:0] l, output logic infl);
    @(negedge clk_rd);
    rd   = fifo_read;
    emp  = fifo_empty;
    x    = m_valid && m_ready;
    d    = m_data;
    l    = level;
    infl = inflight_m;
    @(posedge clk_rd);
    #1;
    if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    inflight_m = rd;
  endtask

  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(base + i));
      exp_q.push_back(DW'(base + i));
    end
  endtask

  task automatic do_reset();
    rst_rd  = 1'b1;
    m_ready = 1'b0;
    tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
    tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
    rst_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_rd  = 1'b1;
    m_ready = 1'b1;
    push(3, 0);
    for (int c = 0; c < 2; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      total++;
      if (t_rd !== 1'b0) begin bad++; $display("FAIL rst_read c=%0d got=%b want=0", c, t_rd); end
      total++;
      if (t_x !== 1'b0) begin bad++; $display("FAIL rst_valid c=%0d got=%b want=0", c, t_x); end
    end
    total++;
    if (level !== 2'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
    total++;
    if (word_cnt !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", word_cnt); end
  endtask

  task automatic test_first_words();
    rst_rd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      total++;
      if (t_rd !== (c < 3)) begin bad++; $display("FAIL first_read c=%0d got=%b want=%b", c, t_rd, c < 3); end
      total++;
      if (t_x !== (c >= 2 && c < 5)) begin bad++; $display("FAIL first_valid c=%0d got=%b want=%b", c, t_x, c >= 2 && c < 5); end
      if (t_x && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (t_d !== e) begin bad++; $display("FAIL first_data c=%0d got=%0d want=%0d", c, t_d, e); end
      end
    end
    total++;
    if (word_cnt !== CW'(3)) begin bad++; $display("FAIL first_cnt got=%0d want=3", word_cnt); end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    int n = 0;
    int first = -1;
    int last = -1;
    push(10, 0);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      if (t_rd) reads++;
    end
    total++;
    if (reads != 2) begin bad++; $display("FAIL bp_reads got=%0d want=2", reads); end
    total++;
    if (level !== 2'd2) begin bad++; $display("FAIL bp_level got=%0d want=2", level); end
    total++;
    if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
      bad++; $display("FAIL bp_hold got=%b/%0d want=1/%0d", m_valid, m_data, exp_q[0]);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 30 && n < 10; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      if (t_x) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        total++;
        if (t_d !== e) begin bad++; $display("FAIL bp_data n=%0d got=%0d want=%0d", n, t_d, e); end
        if (first < 0) first = c;
        last = c;
        n++;
      end
    end
    total++;
    if (n != 10 || last - first != 9) begin bad++; $display("FAIL bp_rate got=%0d words in %0d cycles want=10 in 10", n, last - first + 1); end
    total++;
    if (word_cnt !== CW'(10)) begin bad++; $display("FAIL bp_cnt got=%0d want=10", word_cnt); end
  endtask

  task automatic test_random();
    push(60, 0);
    do_reset();
    for (int c = 0; c < 800 && exp_q.size() > 0; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      total++;
      if (t_rd && t_emp) begin bad++; $display("FAIL rnd_read_empty c=%0d got=1 want=0", c); end
      total++;
      if (({1'b0, t_l} + {2'b0, t_i}) > 3'd2) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d want<=2", c, t_l + t_i); end
      if (t_x) begin
        e = exp_q.pop_front();
        total++;
        if (t_d !== e) begin bad++; $display("FAIL rnd_data c=%0d got=%0d want=%0d", c, t_d, e); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_timeout got=%0d left want=0", exp_q.size()); exp_q.delete(); end
    total++;
    if (word_cnt !== CW'(60)) begin bad++; $display("FAIL rnd_cnt got=%0d want=%0d", word_cnt, CW'(60)); end
  endtask

  task automatic test_reset_midop();
    int n = 0;
    push(5, 0);
    do_reset();
    for (int c = 0; c < 4; c++) tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
    total++;
    if (level !== 2'd2) begin bad++; $display("FAIL mid_fill got=%0d want=2", level); end
    m_ready = 1'b1;
    tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
    e = exp_q.pop_front();
    total++;
    if (t_x !== 1'b1 || t_d !== e || t_rd !== 1'b1) begin
      bad++; $display("FAIL mid_xfer got=%b/%0d/%b want=1/%0d/1", t_x, t_d, t_rd, e);
    end
    total++;
    if (level !== 2'd1 || inflight_m !== 1'b1) begin bad++; $display("FAIL mid_state got=%0d/%b want=1/1", level, inflight_m); end
    rst_rd = 1'b1;
    tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
    rst_rd = 1'b0;
    total++;
    if (level !== 2'd0 || m_valid !== 1'b0 || word_cnt !== '0) begin
      bad++; $display("FAIL mid_rst got=%0d/%b/%0d want=0/0/0", level, m_valid, word_cnt);
    end
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    for (int c = 0; c < 10 && n < 2; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      if (t_x) begin
        e = exp_q.pop_front();
        total++;
        if (t_d !== e) begin bad++; $display("FAIL mid_after n=%0d got=%0d want=%0d", n, t_d, e); end
        n++;
      end
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL mid_drain got=%0d want=2", n); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    int n = 0;
    push(17, 100);
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 60 && n < 17; c++) begin
      tick(t_rd, t_emp, t_x, t_d, t_l, t_i);
      if (t_x) begin
        e = exp_q.pop_front();
        total++;
        if (t_d !== e) begin bad++; $display("FAIL wrap_data n=%0d got=%0d want=%0d", n, t_d, e); end
        n++;
        if (n == 15) begin
          total++;
          if (word_cnt !== CW'(15)) begin bad++; $display("FAIL wrap_15 got=%0d want=15", word_cnt); end
        end
        if (n == 16) begin
          total++;
          if (word_cnt !== CW'(0)) begin bad++; $display("FAIL wrap_16 got=%0d want=0", word_cnt); end
        end
        if (n == 17) begin
          total++;
          if (word_cnt !== CW'(1)) begin bad++; $display("FAIL wrap_17 got=%0d want=1", word_cnt); end
        end
      end
    end
    total++;
    if (n != 17) begin bad++; $display("FAIL wrap_count got=%0d want=17", n); exp_q.delete(); end
  endtask

  initial begin
    rst_rd     = 1'b1;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    inflight_m = 1'b0;
    test_reset();
    test_first_words();
    test_backpressure();
    test_random();
    test_reset_midop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
